// File: rtl/keypad_play_sched_pkg.sv
// Shared constants and types for the keypad sample player.
// Key regions are index-aligned: key k plays KEY_LEN[k] samples starting at KEY_BASE[k].
package play_pkg;
    localparam int NUM_KEYS = 4;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 24;
    localparam int KEY_W    = $clog2(NUM_KEYS);

    typedef logic [ADDR_W-1:0] addr_t;

    // Packed so element 0 is the rightmost literal.
    localparam logic [NUM_KEYS-1:0][ADDR_W-1:0] KEY_BASE = {10'd264, 10'd65, 10'd59, 10'd0};
    localparam logic [NUM_KEYS-1:0][ADDR_W-1:0] KEY_LEN  = {10'd35, 10'd199, 10'd6, 10'd59};

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, PRESENT} play_state_e;
endpackage

// File: rtl/keypad_play_sched_if.sv
// Keypad, sample-ROM and sink signals of the player, bundled as one port.
// The master modport is the player side; the slave modport is the environment side.
interface keypad_play_sched_if;
    import play_pkg::*;

    logic [NUM_KEYS-1:0] key_i;
    logic                rom_en_o;
    logic [ADDR_W-1:0]   rom_addr_o;
    logic [DATA_W-1:0]   rom_data_i;
    logic [DATA_W-1:0]   sample_o;
    logic                valid_o;
    logic                ready_i;
    logic                busy_o;
    logic [KEY_W-1:0]    active_key_o;

    modport master (
        input  key_i, rom_data_i, ready_i,
        output rom_en_o, rom_addr_o, sample_o, valid_o, busy_o, active_key_o
    );
    modport slave (
        output key_i, rom_data_i, ready_i,
        input  rom_en_o, rom_addr_o, sample_o, valid_o, busy_o, active_key_o
    );
endinterface

// File: rtl/keypad_play_sched_key_edge_arb.sv
// Key rising-edge detect with fixed priority (index 0 highest); zero-length keys are masked.
// Latency: combinational grant in the cycle the key rises; no backpressure input.
// Triggers are suppressed for the first cycle after reset so keys held through reset do not fire.
module key_edge_arb
    import play_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic                grant_valid,
    output logic [KEY_W-1:0]    grant_idx
);
    logic [NUM_KEYS-1:0] key_q;
    logic [NUM_KEYS-1:0] trig;
    logic                armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            key_q   <= key;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        trig      = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            trig[k] = armed_q & key[k] & ~key_q[k] & (KEY_LEN[k] != '0);
        for (int k = NUM_KEYS-1; k >= 0; k--)
            if (trig[k]) grant_idx = KEY_W'(k);
        grant_valid = |trig;
    end
endmodule

// File: rtl/keypad_play_sched.sv
// Plays a key's ROM region sample by sample to a valid/ready sink; PLAY_LOOP_EN selects loop-while-held.
// Latency: key edge at T -> ROM fetch at T+1 -> valid at T+3; at most one sample per 3 cycles.
// Backpressure: ready low in PRESENT freezes state and sample, no further ROM reads.
module keypad_play_sched
    import play_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_n_i,
    keypad_play_sched_if.master bus
);
    play_state_e       state_q, state_d;
    logic [KEY_W-1:0]  key_idx_q;
    addr_t             offset_q;
    addr_t             addr_q;
    logic [DATA_W-1:0] sample_q;
    logic              grant_valid;
    logic [KEY_W-1:0]  grant_idx;
    logic              hs;
    logic              last;
    addr_t             fetch_addr;

    key_edge_arb u_arb (
        .clk         (clk_i),
        .rst_n       (reset_n_i),
        .key         (bus.key_i),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign hs         = (state_q == PRESENT) && bus.ready_i;
    assign last       = (offset_q == KEY_LEN[key_idx_q] - addr_t'(1));
    assign fetch_addr = KEY_BASE[key_idx_q] + offset_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = FETCH;
            FETCH:   state_d = WAIT;
            WAIT:    state_d = PRESENT;
            PRESENT: if (hs) begin
`ifdef PLAY_LOOP_EN
                // Release is only honoured at a handshake, so the sample on the bus completes.
                state_d = bus.key_i[key_idx_q] ? FETCH : IDLE;
`else
                state_d = last ? IDLE : FETCH;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            key_idx_q <= '0;
            offset_q  <= '0;
            addr_q    <= '0;
            sample_q  <= '0;
        end else begin
            if (state_q == IDLE && grant_valid) begin
                key_idx_q <= grant_idx;
                offset_q  <= '0;
            end
            if (state_q == FETCH) addr_q   <= fetch_addr;
            if (state_q == WAIT)  sample_q <= bus.rom_data_i;
            if (hs)               offset_q <= last ? '0 : offset_q + addr_t'(1);
        end
    end

    always_comb begin
        bus.rom_en_o     = (state_q == FETCH);
        bus.rom_addr_o   = (state_q == FETCH) ? fetch_addr : addr_q;
        bus.valid_o      = (state_q == PRESENT);
        bus.sample_o     = sample_q;
        bus.busy_o       = (state_q != IDLE);
        bus.active_key_o = key_idx_q;
    end
endmodule

// File: tb/tb_keypad_play_sched.sv
// Directed bench for keypad_play_sched with a region-level playback model and per-cycle compare.
module tb_keypad_play_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   exp_key = 0;
    int   hs_total = 0;
    logic [9:0] last_hs_addr = '0;

    localparam int BASE [4] = '{0, 59, 65, 264};
    localparam int LEN  [4] = '{59, 6, 199, 35};

    keypad_play_sched_if bus();

    keypad_play_sched dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_f(input logic [9:0] a);
        return {4'hA, a, a ^ 10'h2AA};
    endfunction

    // Address of the n-th sample of key k's region (wraps within the region for looping).
    function automatic logic [9:0] exp_addr(input int k, input int n);
        return 10'((BASE[k] + (n % LEN[k])) % 1024);
    endfunction

    // ROM answers one cycle after the strobe; garbage otherwise so a mistimed capture shows.
    always @(posedge clk) begin
        if (bus.rom_en_o) bus.rom_data_i <= rom_f(bus.rom_addr_o);
        else              bus.rom_data_i <= 24'($urandom);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    int          hs_n, fetch_n, since_fetch;
    logic        prev_busy, prev_valid, prev_ready;
    logic [9:0]  prev_addr;
    logic [23:0] prev_sample;

    always @(negedge clk) begin
        if (!rst_n) begin
            hs_n = 0; fetch_n = 0; since_fetch = 99;
            prev_busy = 0; prev_valid = 0; prev_ready = 0;
            prev_addr = '0; prev_sample = '0;
        end else begin
            if (bus.busy_o && !prev_busy) begin hs_n = 0; fetch_n = 0; end
            if (bus.busy_o) check("active_key", 32'(bus.active_key_o), exp_key);
            if (bus.rom_en_o) begin
                check("fetch_addr", 32'(bus.rom_addr_o), 32'(exp_addr(exp_key, fetch_n)));
                check("fetch_busy", 32'(bus.busy_o), 1);
                fetch_n++;
                since_fetch = 0;
            end else begin
                check("addr_hold", 32'(bus.rom_addr_o), 32'(prev_addr));
                since_fetch++;
            end
            if (bus.valid_o && !prev_valid) check("valid_2_after_fetch", since_fetch, 2);
            if (prev_valid && !prev_ready) begin
                check("valid_held", 32'(bus.valid_o), 1);
                check("sample_held", 32'(bus.sample_o), 32'(prev_sample));
            end
            if (bus.valid_o && bus.ready_i) begin
                check("sample_data", 32'(bus.sample_o), 32'(rom_f(exp_addr(exp_key, hs_n))));
                hs_n++;
                hs_total++;
                last_hs_addr = bus.sample_o[19:10];
            end
`ifndef PLAY_LOOP_EN
            if (prev_busy && !bus.busy_o) check("region_len", hs_n, LEN[exp_key]);
`endif
            prev_busy   = bus.busy_o;
            prev_valid  = bus.valid_o;
            prev_ready  = bus.ready_i;
            prev_addr   = bus.rom_addr_o;
            prev_sample = bus.sample_o;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int c = 0;
        while (bus.busy_o && c < max) begin tick(); c++; end
        check({tag, "_idle_timeout"}, 32'(bus.busy_o), 0);
    endtask

    // Called right after the key edge is driven; walks cycles T..T+3.
    task automatic watch_start(input string tag, input logic [9:0] a0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) check({tag, "_idle_at_t"}, 32'(bus.busy_o), 0);
            if (i == 1) begin
                check({tag, "_fetch_en"}, 32'(bus.rom_en_o), 1);
                check({tag, "_addr0"}, 32'(bus.rom_addr_o), 32'(a0));
            end
            if (i == 2) check({tag, "_no_early_valid"}, 32'(bus.valid_o), 0);
            if (i == 3) check({tag, "_valid_t3"}, 32'(bus.valid_o), 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int k, input logic [3:0] keys);
        bus.key_i = '0;
        tick(2);
        exp_key  = k;
        hs_total = 0;
        bus.key_i = keys;
    endtask

    initial begin
        int busy_cnt;
        int c;
        logic [23:0] s0;
        rst_n = 1'b1;
        bus.key_i = '0;
        bus.ready_i = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_rom_en", 32'(bus.rom_en_o), 0);
        check("rst_valid", 32'(bus.valid_o), 0);
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_addr", 32'(bus.rom_addr_o), 0);
        check("rst_sample", 32'(bus.sample_o), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

`ifndef PLAY_LOOP_EN
        // 1: key1 plays 59..64 once
        start(1, 4'b0010);
        watch_start("t1", 10'd59);
        wait_idle("t1", 100);
        check("t1_handshakes", hs_total, 6);
        check("t1_last_addr", 32'(last_hs_addr), 64);

        // 2: key0 and key2 together -> key0 only
        start(0, 4'b0101);
        watch_start("t2", 10'd0);
        wait_idle("t2", 400);
        check("t2_handshakes", hs_total, 59);
        bus.key_i = '0;
        tick(6);
        check("t2_key2_dropped", 32'(bus.busy_o), 0);

        // 3: sink stalls for 5 cycles on the first sample
        bus.ready_i = 1'b0;
        start(1, 4'b0010);
        watch_start("t3", 10'd59);
        s0 = bus.sample_o;
        check("t3_first_sample", 32'(s0), 32'h00A0EE91);
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_valid", 32'(bus.valid_o), 1);
            check("t3_stall_no_rom", 32'(bus.rom_en_o), 0);
            check("t3_stall_sample", 32'(bus.sample_o), 32'(s0));
            tick();
        end
        bus.ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_resume_en", 32'(bus.rom_en_o), 1);
        check("t3_resume_addr", 32'(bus.rom_addr_o), 60);
        tick();
        wait_idle("t3", 100);
        check("t3_handshakes", hs_total, 6);

        // 4: key3 pressed mid-playback is ignored until re-pressed
        start(0, 4'b0001);
        watch_start("t4", 10'd0);
        tick(5);
        bus.key_i = 4'b1001;
        wait_idle("t4", 400);
        check("t4_handshakes", hs_total, 59);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (bus.busy_o) busy_cnt++; end
        check("t4_held_key3_idle", busy_cnt, 0);
        bus.key_i = 4'b0001;
        tick();
        exp_key = 3;
        hs_total = 0;
        bus.key_i = 4'b1001;
        watch_start("t4b", 10'd264);
        wait_idle("t4b", 200);
        check("t4b_handshakes", hs_total, 35);
        check("t4b_last_addr", 32'(last_hs_addr), 298);

        // 5: reset pulse while presenting, keys held through it
        bus.ready_i = 1'b0;
        start(2, 4'b0100);
        watch_start("t5", 10'd65);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(bus.valid_o), 0);
        check("t5_rst_busy", 32'(bus.busy_o), 0);
        check("t5_rst_rom_en", 32'(bus.rom_en_o), 0);
        check("t5_rst_addr", 32'(bus.rom_addr_o), 0);
        check("t5_rst_sample", 32'(bus.sample_o), 0);
        check("t5_rst_key", 32'(bus.active_key_o), 0);
        tick(2);
        rst_n = 1'b1;
        bus.ready_i = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (bus.busy_o) busy_cnt++; end
        check("t5_held_after_reset", busy_cnt, 0);
        start(1, 4'b0010);
        watch_start("t5r", 10'd59);
        wait_idle("t5r", 100);
        check("t5r_handshakes", hs_total, 6);
`else
        // 6: loop while held, release during the 14th sample
        start(1, 4'b0010);
        watch_start("t6", 10'd59);
        c = 0;
        do begin
            @(negedge clk);
            #1;
            c++;
        end while (!(bus.valid_o && hs_total == 14) && c < 300);
        check("t6_reach_14", hs_total, 14);
        bus.key_i = '0;
        tick();
        check("t6_idle_after_release", 32'(bus.busy_o), 0);
        wait_idle("t6", 20);
        check("t6_handshakes", hs_total, 14);
        check("t6_last_addr", 32'(last_hs_addr), 60);
`endif
        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
